// File: rtl/mux2_bus_arbiter.sv
// Two-requester round-robin arbiter that owns the 2:1 data select and
// sequences one len+1 beat burst per grant over a valid/ready handshake.
module mux2_bus_arbiter #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [LEN_W-1:0]  len0,
    input  logic [DATA_W-1:0] data0,
    input  logic              req1,
    input  logic [LEN_W-1:0]  len1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic              sel,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q;
    logic               sel_q;
    logic               last_sel_q;
    logic               gnt0_q;
    logic               gnt1_q;
    logic [LEN_W-1:0]   cnt_q;
    logic               win_d;

    // Under contention the requester that did not win last time goes next.
    always_comb begin
        win_d = (req0 && req1) ? ~last_sel_q : req1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            last_sel_q <= 1'b1;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        state_q    <= BUSY;
                        sel_q      <= win_d;
                        last_sel_q <= win_d;
                        cnt_q      <= win_d ? len1 : len0;
                        gnt0_q     <= ~win_d;
                        gnt1_q     <= win_d;
                    end
                end
                BUSY: begin
                    // cnt counts remaining beats after the current one.
                    if (out_ready) begin
                        if (cnt_q == '0) begin
                            state_q <= IDLE;
                            gnt0_q  <= 1'b0;
                            gnt1_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - LEN_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign sel       = sel_q;
    assign out_valid = (state_q == BUSY);
    assign out_last  = (state_q == BUSY) && (cnt_q == '0);
    assign ack0      = gnt0_q & out_ready;
    assign ack1      = gnt1_q & out_ready;
    assign out_data  = sel_q ? data1 : data0;

endmodule

// File: tb/tb_mux2_bus_arbiter.sv
// Bench for mux2_bus_arbiter: fixed vector table, targeted burst sequences,
// and random traffic against an owner/beats-left reference model.
module tb_mux2_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst, req0, req1, out_ready;
    logic [3:0]  len0, len1;
    logic [31:0] data0, data1;
    logic        gnt0, gnt1, ack0, ack1, sel, out_valid, out_last;
    logic [31:0] out_data;

    always #5 clk = ~clk;

    mux2_bus_arbiter #(.DATA_W(32), .LEN_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .len0(len0), .data0(data0),
        .req1(req1), .len1(len1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .sel(sel), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: who owns the port (-1 = nobody) and beats still to send.
    int m_owner = -1;
    int m_left  = 0;
    int m_last  = 1;
    int m_sel   = 0;

    logic [38:0] obs;

    function automatic logic [38:0] dut_out();
        return {gnt0, gnt1, sel, out_valid, out_last, ack0, ack1, out_data};
    endfunction

    function automatic logic [38:0] model_out();
        logic g0, g1, v, l, s;
        g0 = (m_owner == 0);
        g1 = (m_owner == 1);
        v  = (m_owner >= 0);
        l  = v && (m_left == 1);
        s  = (m_sel != 0);
        return {g0, g1, s, v, l, g0 & out_ready, g1 & out_ready, s ? data1 : data0};
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_owner = -1; m_left = 0; m_last = 1; m_sel = 0;
        end else if (m_owner >= 0) begin
            if (out_ready) begin
                m_left = m_left - 1;
                if (m_left == 0) m_owner = -1;
            end
        end else if (req0 || req1) begin
            int w;
            if (req0 && req1) w = 1 - m_last;
            else              w = req0 ? 0 : 1;
            m_owner = w; m_sel = w; m_last = w;
            m_left  = (w == 1 ? int'(len1) : int'(len0)) + 1;
        end
    endtask

    task automatic cmp(input string name, input logic [38:0] act, input logic [38:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmp_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs are driven just after negedge; outputs sampled 2ns later.
    task automatic step(input string name);
        #2;
        obs = dut_out();
        cmp(name, obs, model_out());
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drain();
        req0 = 0; req1 = 0; out_ready = 1;
        for (int k = 0; k < 20 && m_owner >= 0; k++) step("drain");
        step("drain_idle");
    endtask

    typedef struct {
        logic       r0, r1, rdy;
        logic [3:0] l0, l1;
        logic [6:0] ctl;   // gnt0 gnt1 sel valid last ack0 ack1
    } vec_t;

    vec_t vecs[12];

    initial begin
        int acks, busy, sel_bad, last_cnt, last_at, first_g1, g1_beats;

        vecs[0]  = '{1, 0, 1, 4'd0, 4'd0, 7'b0000000};
        vecs[1]  = '{0, 0, 1, 4'd0, 4'd0, 7'b1001110};
        vecs[2]  = '{0, 0, 1, 4'd0, 4'd0, 7'b0000000};
        vecs[3]  = '{1, 1, 1, 4'd2, 4'd2, 7'b0000000};
        vecs[4]  = '{1, 1, 1, 4'd2, 4'd2, 7'b0111001};
        vecs[5]  = '{1, 1, 1, 4'd2, 4'd2, 7'b0111001};
        vecs[6]  = '{1, 1, 1, 4'd2, 4'd2, 7'b0111101};
        vecs[7]  = '{1, 1, 1, 4'd2, 4'd2, 7'b0010000};
        vecs[8]  = '{1, 1, 1, 4'd2, 4'd2, 7'b1001010};
        vecs[9]  = '{1, 1, 1, 4'd2, 4'd2, 7'b1001010};
        vecs[10] = '{1, 1, 1, 4'd2, 4'd2, 7'b1001110};
        vecs[11] = '{0, 0, 1, 4'd2, 4'd2, 7'b0000000};

        rst = 1; req0 = 0; req1 = 0; out_ready = 0;
        len0 = 0; len1 = 0; data0 = 32'h11111111; data1 = 32'h22222222;
        @(negedge clk);
        @(posedge clk); model_edge(); @(negedge clk);
        req0 = 1; req1 = 1;          // reset must win over a request
        step("reset_state");
        rst = 0; req0 = 0; req1 = 0;

        for (int i = 0; i < 12; i++) begin
            req0 = vecs[i].r0; req1 = vecs[i].r1; out_ready = vecs[i].rdy;
            len0 = vecs[i].l0; len1 = vecs[i].l1;
            #2;
            cmp($sformatf("vec%0d", i), dut_out(),
                {vecs[i].ctl, vecs[i].ctl[4] ? data1 : data0});
            @(posedge clk); model_edge(); @(negedge clk);
        end

        // Requester 1, len 3, out_ready toggling starting high.
        req1 = 1; len1 = 3; out_ready = 1;
        step("tog_grant");
        req1 = 0; acks = 0; busy = 0; sel_bad = 0;
        for (int k = 0; k < 9; k++) begin
            out_ready = (k % 2 == 0);
            data1 = $urandom;
            step("tog_beat");
            if (obs[35]) begin
                busy++;
                if (!obs[36] || obs[31:0] !== data1) sel_bad++;
            end
            if (obs[32]) acks++;
        end
        cmp_int("tog_acks", acks, 4);
        cmp_int("tog_busy_cycles", busy, 7);
        cmp_int("tog_sel_data", sel_bad, 0);
        drain();

        // Maximum burst on requester 0.
        req0 = 1; len0 = 15; out_ready = 1;
        step("max_grant");
        req0 = 0; acks = 0; last_cnt = 0; last_at = 0;
        for (int k = 0; k < 18; k++) begin
            data0 = $urandom;
            step("max_beat");
            if (obs[33]) begin
                acks++;
                if (obs[34]) begin last_cnt++; last_at = acks; end
            end
        end
        cmp_int("max_acks", acks, 16);
        cmp_int("max_last_count", last_cnt, 1);
        cmp_int("max_last_pos", last_at, 16);
        drain();

        // Reset after 2 of 8 beats, then contention goes to requester 0.
        req0 = 1; len0 = 7; out_ready = 1;
        step("rm_grant");
        req0 = 0;
        step("rm_beat"); step("rm_beat");
        rst = 1;
        step("rm_rst");
        rst = 0;
        step("rm_after");
        cmp("rm_after_zero", {obs[38:32], 32'h0}, 39'h0);
        req0 = 1; req1 = 1; len0 = 0; len1 = 0;
        step("rm_cont");
        step("rm_cont_gnt");
        cmp("rm_cont_winner", {obs[38:37], 37'h0}, {2'b10, 37'h0});
        drain();

        // req1 waits through requester 0's burst; len1 sampled at its grant.
        req0 = 1; len0 = 2; out_ready = 1;
        step("wait_grant0");
        req0 = 0; req1 = 1; len1 = 5;
        first_g1 = -1; g1_beats = 0;
        for (int t = 0; t < 10; t++) begin
            if (t == 3) len1 = 1;
            if (t == 4) begin req1 = 0; len1 = 9; end
            step("wait_seq");
            if (obs[37]) begin
                g1_beats++;
                if (first_g1 < 0) first_g1 = t;
            end
        end
        cmp_int("wait_first_g1", first_g1, 4);
        cmp_int("wait_g1_beats", g1_beats, 2);
        drain();

        // Random traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            rst       = ($urandom_range(0, 99) < 2);
            req0      = ($urandom_range(0, 9) < 6);
            req1      = ($urandom_range(0, 9) < 6);
            len0      = 4'($urandom_range(0, 15));
            len1      = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            data0     = $urandom;
            data1     = $urandom;
            step("rand");
        end
        rst = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
